// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: arbitrates button pulses, drives timer enable/rate and counter clear,
// and holds a lap value on the display for HOLD_TICKS seconds while counting continues.
module stopwatch_ctrl #(
    parameter int unsigned HOLD_TICKS = 5
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       one_pulse,
    input  logic       ten_pulse,
    input  logic       pause_pulse,
    input  logic       clear_pulse,
    input  logic       lap_pulse,
    input  logic       second_tick,
    input  logic [7:0] live_bcd,
    output logic       timer_enable,
    output logic       ten_sec_mode,
    output logic       counter_clear,
    output logic [7:0] disp_bcd,
    output logic       lap_active,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN_ONE = 3'd1,
        S_RUN_TEN = 3'd2,
        S_PAUSED  = 3'd3,
        S_LAP     = 3'd4
    } state_e;

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_TICKS);

    state_e     state_q, state_d;
    logic [7:0] lap_reg_q, lap_reg_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       saved_mode_q, saved_mode_d;
    logic       clear_q, clear_d;

    // Exactly one pulse acts per cycle: clear > pause > lap > ten > one.
    logic act_clear, act_pause, act_lap, act_ten, act_one;
    assign act_clear = clear_pulse;
    assign act_pause = pause_pulse & ~act_clear;
    assign act_lap   = lap_pulse   & ~act_clear & ~pause_pulse;
    assign act_ten   = ten_pulse   & ~act_clear & ~pause_pulse & ~lap_pulse;
    assign act_one   = one_pulse   & ~act_clear & ~pause_pulse & ~lap_pulse & ~ten_pulse;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            lap_reg_q    <= 8'h00;
            hold_cnt_q   <= 8'd0;
            saved_mode_q <= 1'b0;
            clear_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lap_reg_q    <= lap_reg_d;
            hold_cnt_q   <= hold_cnt_d;
            saved_mode_q <= saved_mode_d;
            clear_q      <= clear_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        lap_reg_d    = lap_reg_q;
        hold_cnt_d   = hold_cnt_q;
        saved_mode_d = saved_mode_q;
        clear_d      = 1'b0;
        if (act_clear) begin
            state_d      = S_IDLE;
            lap_reg_d    = 8'h00;
            hold_cnt_d   = 8'd0;
            saved_mode_d = 1'b0;
            clear_d      = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (act_ten) begin
                        state_d      = S_RUN_TEN;
                        saved_mode_d = 1'b1;
                    end else if (act_one) begin
                        state_d      = S_RUN_ONE;
                        saved_mode_d = 1'b0;
                    end
                end
                S_RUN_ONE, S_RUN_TEN, S_PAUSED: begin
                    if (act_pause) begin
                        if (state_q == S_PAUSED) state_d = saved_mode_q ? S_RUN_TEN : S_RUN_ONE;
                        else                     state_d = S_PAUSED;
                    end else if (act_lap && state_q != S_PAUSED) begin
                        state_d    = S_LAP;
                        lap_reg_d  = live_bcd;
                        hold_cnt_d = 8'd0;
                    end else if (act_ten) begin
                        state_d      = S_RUN_TEN;
                        saved_mode_d = 1'b1;
                    end else if (act_one) begin
                        state_d      = S_RUN_ONE;
                        saved_mode_d = 1'b0;
                    end
                end
                S_LAP: begin
                    if (act_pause) begin
                        state_d = S_PAUSED;
                    end else if (act_lap) begin
                        // Re-capture takes precedence over a coincident second_tick.
                        lap_reg_d  = live_bcd;
                        hold_cnt_d = 8'd0;
                    end else begin
                        if (act_ten)      saved_mode_d = 1'b1;
                        else if (act_one) saved_mode_d = 1'b0;
                        if (second_tick && hold_cnt_q < HOLD_MAX) hold_cnt_d = hold_cnt_q + 8'd1;
                        if (hold_cnt_q >= HOLD_MAX) state_d = saved_mode_d ? S_RUN_TEN : S_RUN_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        timer_enable = 1'b0;
        lap_active   = 1'b0;
        unique case (state_q)
            S_RUN_ONE, S_RUN_TEN: timer_enable = 1'b1;
            S_LAP: begin
                timer_enable = 1'b1;
                lap_active   = 1'b1;
            end
            default: ;
        endcase
    end

    assign ten_sec_mode  = saved_mode_q;
    assign counter_clear = clear_q;
    assign state         = state_q;
    assign disp_bcd      = lap_active ? lap_reg_q : live_bcd;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: expected output vectors are queued as stimulus
// is driven and popped for comparison once the DUT has taken the clock edge.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       one_pulse, ten_pulse, pause_pulse, clear_pulse, lap_pulse, second_tick;
    logic [7:0] live_bcd;
    logic       timer_enable, ten_sec_mode, counter_clear, lap_active;
    logic [7:0] disp_bcd;
    logic [2:0] state;

    stopwatch_ctrl #(.HOLD_TICKS(5)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .one_pulse    (one_pulse),
        .ten_pulse    (ten_pulse),
        .pause_pulse  (pause_pulse),
        .clear_pulse  (clear_pulse),
        .lap_pulse    (lap_pulse),
        .second_tick  (second_tick),
        .live_bcd     (live_bcd),
        .timer_enable (timer_enable),
        .ten_sec_mode (ten_sec_mode),
        .counter_clear(counter_clear),
        .disp_bcd     (disp_bcd),
        .lap_active   (lap_active),
        .state        (state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_CLR  = 6'b100000;
    localparam logic [5:0] P_PAU  = 6'b010000;
    localparam logic [5:0] P_LAP  = 6'b001000;
    localparam logic [5:0] P_TEN  = 6'b000100;
    localparam logic [5:0] P_ONE  = 6'b000010;
    localparam logic [5:0] P_TCK  = 6'b000001;

    typedef struct {
        string       name;
        logic [14:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Vector layout: {state, timer_enable, ten_sec_mode, counter_clear, lap_active, disp_bcd}
    function automatic logic [14:0] pk(input logic [2:0] s, input logic te, input logic tm,
                                       input logic cc, input logic la, input logic [7:0] d);
        return {s, te, tm, cc, la, d};
    endfunction

    function automatic logic [14:0] obs();
        return {state, timer_enable, ten_sec_mode, counter_clear, lap_active, disp_bcd};
    endfunction

    function automatic void expect_v(input string name, input logic [14:0] v);
        exp_t x;
        x.name = name;
        x.v    = v;
        sb.push_back(x);
    endfunction

    // Called at #1 after a posedge: drives pulses for one cycle and returns #1 after the next edge.
    task automatic step(input logic [5:0] p);
        {clear_pulse, pause_pulse, lap_pulse, ten_pulse, one_pulse, second_tick} = p;
        @(posedge clk);
        #1;
        {clear_pulse, pause_pulse, lap_pulse, ten_pulse, one_pulse, second_tick} = P_NONE;
    endtask

    task automatic test_reset();
        n_rst    = 1'b0;
        live_bcd = 8'h12;
        {clear_pulse, pause_pulse, lap_pulse, ten_pulse, one_pulse, second_tick} = P_NONE;
        #3;
        expect_v("reset", pk(3'd0, 0, 0, 0, 0, 8'h12));
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        #4 n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_start();
        expect_v("one_start", pk(3'd1, 1, 0, 0, 0, 8'h12));
        step(P_ONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("one_again_noop", pk(3'd1, 1, 0, 0, 0, 8'h12));
        step(P_ONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
    endtask

    task automatic test_pause_resume();
        expect_v("pause", pk(3'd3, 0, 0, 0, 0, 8'h12));
        step(P_PAU);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("resume_one", pk(3'd1, 1, 0, 0, 0, 8'h12));
        step(P_PAU);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("switch_ten_no_clear", pk(3'd2, 1, 1, 0, 0, 8'h12));
        step(P_TEN);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
    endtask

    task automatic test_lap();
        logic [7:0] lv [5] = '{8'h38, 8'h39, 8'h40, 8'h41, 8'h42};
        live_bcd = 8'h37;
        expect_v("lap_capture", pk(3'd4, 1, 1, 0, 1, 8'h37));
        step(P_LAP);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        for (int i = 0; i < 5; i++) begin
            live_bcd = lv[i];
            expect_v($sformatf("lap_hold_tick%0d", i + 1), pk(3'd4, 1, 1, 0, 1, 8'h37));
            step(P_TCK);
            e = sb.pop_front(); tests_run++;
            if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        end
        live_bcd = 8'h43;
        expect_v("lap_auto_return", pk(3'd2, 1, 1, 0, 0, 8'h43));
        step(P_NONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
    endtask

    task automatic test_lap_recapture();
        live_bcd = 8'h50;
        expect_v("recap_first", pk(3'd4, 1, 1, 0, 1, 8'h50));
        step(P_LAP);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        for (int i = 0; i < 4; i++) begin
            expect_v($sformatf("recap_pre_tick%0d", i + 1), pk(3'd4, 1, 1, 0, 1, 8'h50));
            step(P_TCK);
            e = sb.pop_front(); tests_run++;
            if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        end
        live_bcd = 8'h55;
        expect_v("recap_with_tick", pk(3'd4, 1, 1, 0, 1, 8'h55));
        step(P_LAP | P_TCK);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        for (int i = 0; i < 2; i++) begin
            expect_v($sformatf("recap_tick%0d", i + 1), pk(3'd4, 1, 1, 0, 1, 8'h55));
            step(P_TCK);
            e = sb.pop_front(); tests_run++;
            if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        end
        expect_v("lap_select_one", pk(3'd4, 1, 0, 0, 1, 8'h55));
        step(P_ONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        for (int i = 2; i < 5; i++) begin
            expect_v($sformatf("recap_tick%0d", i + 1), pk(3'd4, 1, 0, 0, 1, 8'h55));
            step(P_TCK);
            e = sb.pop_front(); tests_run++;
            if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        end
        expect_v("recap_return_one", pk(3'd1, 1, 0, 0, 0, 8'h55));
        step(P_NONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
    endtask

    task automatic test_clear_priority();
        expect_v("clear_over_pause_one", pk(3'd0, 0, 0, 1, 0, 8'h55));
        step(P_CLR | P_PAU | P_ONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("clear_one_cycle", pk(3'd0, 0, 0, 0, 0, 8'h55));
        step(P_NONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("idle_pause_ignored", pk(3'd0, 0, 0, 0, 0, 8'h55));
        step(P_PAU);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("idle_lap_ignored", pk(3'd0, 0, 0, 0, 0, 8'h55));
        step(P_LAP);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("idle_ten_over_one", pk(3'd2, 1, 1, 0, 0, 8'h55));
        step(P_TEN | P_ONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
    endtask

    task automatic test_lap_priority();
        live_bcd = 8'h61;
        expect_v("lap_over_rates", pk(3'd4, 1, 1, 0, 1, 8'h61));
        step(P_LAP | P_TEN | P_ONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        live_bcd = 8'h62;
        expect_v("pause_over_lap", pk(3'd3, 0, 1, 0, 0, 8'h62));
        step(P_PAU | P_LAP);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("paused_lap_ignored", pk(3'd3, 0, 1, 0, 0, 8'h62));
        step(P_LAP);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("paused_resume_ten", pk(3'd2, 1, 1, 0, 0, 8'h62));
        step(P_PAU);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("lap_again", pk(3'd4, 1, 1, 0, 1, 8'h62));
        step(P_LAP);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
    endtask

    task automatic test_async_reset();
        live_bcd = 8'h63;
        #2 n_rst = 1'b0;
        #1;
        expect_v("async_reset_in_lap", pk(3'd0, 0, 0, 0, 0, 8'h63));
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
        expect_v("post_reset_ten", pk(3'd2, 1, 1, 0, 0, 8'h63));
        step(P_TEN);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        expect_v("clear_before_reset", pk(3'd0, 0, 0, 1, 0, 8'h63));
        step(P_CLR);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        #2 n_rst = 1'b0;
        #1;
        expect_v("async_reset_kills_clear", pk(3'd0, 0, 0, 0, 0, 8'h63));
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
        expect_v("post_reset_one", pk(3'd1, 1, 0, 0, 0, 8'h63));
        step(P_ONE);
        e = sb.pop_front(); tests_run++;
        if (obs() !== e.v) begin tests_failed++; $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v); end
    endtask

    initial begin
        test_reset();
        test_one_start();
        test_pause_resume();
        test_lap();
        test_lap_recapture();
        test_clear_priority();
        test_lap_priority();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
